reg_file_shadow: RTL and testbench

- Parametrised successor to the CPU's 8x8 register file: configurable data width and register count, optional write-to-read bypass, optional hardwired-zero R0.
- Adds a shadow bank plus a sequential save/restore engine that copies active<->shadow one register per cycle, for fast context switch on interrupt entry/exit.
- Sits between the ALU result bus and the ALU operand muxes, replacing the current register file in the single-cycle datapath.

---
 rtl/reg_file_shadow_if.sv | 37 +++
 rtl/reg_file_shadow.sv | 146 ++++++++++++++
 tb/tb_reg_file_shadow.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_file_shadow_if.sv
// ----------------------------------------------------------------------------
// reg_file_shadow_if
// Bundles the register file's datapath and context-switch control signals.
//   master : drives write data/address/enable, read addresses, SAVE/RESTORE;
//            receives read data, BUSY, DONE, WR_DROP (datapath / controller).
//   slave  : the register file itself.
// Parameters: WIDTH (data bits), DEPTH (register count, power of 2, >= 2).
// ----------------------------------------------------------------------------
interface reg_file_shadow_if #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] IN;
  logic [AW-1:0]    INADDRESS;
  logic             WRITE;
  logic [AW-1:0]    OUT1ADDRESS;
  logic [AW-1:0]    OUT2ADDRESS;
  logic [WIDTH-1:0] OUT1;
  logic [WIDTH-1:0] OUT2;
  logic             SAVE;
  logic             RESTORE;
  logic             BUSY;
  logic             DONE;
  logic             WR_DROP;

  modport master (
    output IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, SAVE, RESTORE,
    input  OUT1, OUT2, BUSY, DONE, WR_DROP
  );

  modport slave (
    input  IN, INADDRESS, WRITE, OUT1ADDRESS, OUT2ADDRESS, SAVE, RESTORE,
    output OUT1, OUT2, BUSY, DONE, WR_DROP
  );
endinterface

// File: rtl/reg_file_shadow.sv
// ----------------------------------------------------------------------------
// reg_file_shadow
// Parametrised register file with two combinational read ports, one write
// port, and a shadow bank. A save/restore engine copies active <-> shadow one
// register per cycle for fast context switching on interrupt entry/exit.
//
// Ports:
//   CLK      clock, all state updates on the rising edge
//   RESET    asynchronous active-high reset (clears both banks, aborts copy)
//   bus      reg_file_shadow_if.slave:
//              IN/INADDRESS/WRITE        write port (accepted only when idle)
//              OUT1ADDRESS/OUT1          read port 1 (combinational)
//              OUT2ADDRESS/OUT2          read port 2 (combinational)
//              SAVE/RESTORE              copy requests, level-sampled in idle
//              BUSY                      copy in progress
//              DONE                      high during the final copy cycle
//              WR_DROP                   pulse after a write refused while busy
//
// RD_DLY / WR_DLY are timing annotations for behavioural models of the old
// register file; this implementation is zero-delay, so they are only range
// checked here.
// ----------------------------------------------------------------------------
module reg_file_shadow #(
  parameter int WIDTH   = 8,
  parameter int DEPTH   = 8,
  parameter bit BYPASS  = 1'b0,
  parameter bit ZERO_R0 = 1'b0,
  parameter int RD_DLY  = 2,
  parameter int WR_DLY  = 1
) (
  input logic               CLK,
  input logic               RESET,
  reg_file_shadow_if.slave  bus
);

  localparam int AW = $clog2(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || RD_DLY < 0 || WR_DLY < 0)
  begin : g_param_check
    $error("reg_file_shadow: DEPTH must be a power of 2 >= 2, delays >= 0");
  end

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] S_COPY = 2'd1;
  localparam logic [1:0] R_COPY = 2'd2;

  logic [WIDTH-1:0] active_q [DEPTH];
  logic [WIDTH-1:0] shadow_q [DEPTH];
  logic [1:0]       state_q;
  logic [AW-1:0]    idx_q;
  logic             wr_drop_q;

  logic busy;
  logic last_idx;
  logic wr_accept;
  logic wr_fwd;
  logic restore_en;

  assign busy     = (state_q != IDLE);
  assign last_idx = (idx_q == AW'(DEPTH - 1));

  // Writes to a hardwired R0 are simply never stored, so R0 stays 0 through
  // writes and restores alike and the shadow copy of R0 is always 0 too.
  assign wr_accept  = bus.WRITE && (state_q == IDLE) &&
                      !(ZERO_R0 && (bus.INADDRESS == '0));
  assign restore_en = (state_q == R_COPY) && !(ZERO_R0 && (idx_q == '0));

  // Forwarding is only legal when the write will actually land this edge.
  assign wr_fwd = BYPASS && bus.WRITE && !busy;

  // --------------------------------------------------------------------------
  // Control: copy FSM, copy index, dropped-write flag
  // --------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      wr_drop_q <= 1'b0;
    end else begin
      wr_drop_q <= bus.WRITE && busy;
      case (state_q)
        IDLE: begin
          idx_q <= '0;
          // SAVE has priority when both requests are present.
          if (bus.SAVE)         state_q <= S_COPY;
          else if (bus.RESTORE) state_q <= R_COPY;
        end
        S_COPY, R_COPY: begin
          idx_q <= idx_q + 1'b1;
          if (last_idx) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Storage: active and shadow banks
  // --------------------------------------------------------------------------
  // NOTE: both banks are cleared by reset, which rules out RAM macros; that
  // is intended, since a context restore must never see stale data.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        active_q[i] <= '0;
        shadow_q[i] <= '0;
      end
    end else begin
      // A write accepted on the edge a copy starts is stored before the
      // first copy edge, so the copy picks it up naturally.
      if (wr_accept)             active_q[bus.INADDRESS] <= bus.IN;
      if (state_q == S_COPY)     shadow_q[idx_q]         <= active_q[idx_q];
      if (restore_en)            active_q[idx_q]         <= shadow_q[idx_q];
    end
  end

  // --------------------------------------------------------------------------
  // Read ports
  // --------------------------------------------------------------------------
  logic [WIDTH-1:0] out1_d;
  logic [WIDTH-1:0] out2_d;

  // NOTE: each output gets its default value first so no path through the
  // block leaves it unassigned (which would infer a latch).
  always_comb begin
    out1_d = active_q[bus.OUT1ADDRESS];
    out2_d = active_q[bus.OUT2ADDRESS];
    if (wr_fwd && (bus.INADDRESS == bus.OUT1ADDRESS)) out1_d = bus.IN;
    if (wr_fwd && (bus.INADDRESS == bus.OUT2ADDRESS)) out2_d = bus.IN;
    // Applied last so a hardwired R0 overrides any forwarded value.
    if (ZERO_R0 && (bus.OUT1ADDRESS == '0)) out1_d = '0;
    if (ZERO_R0 && (bus.OUT2ADDRESS == '0)) out2_d = '0;
  end

  assign bus.OUT1    = out1_d;
  assign bus.OUT2    = out2_d;
  assign bus.BUSY    = busy;
  assign bus.DONE    = busy && last_idx;
  assign bus.WR_DROP = wr_drop_q;

endmodule

// File: tb/tb_reg_file_shadow.sv
// ----------------------------------------------------------------------------
// tb_reg_file_shadow
// Directed bench for reg_file_shadow. Three instances receive identical
// stimulus: base (defaults), byp (BYPASS=1) and zero (ZERO_R0=1); each is
// compared against hand-computed values for its configuration.
// ----------------------------------------------------------------------------
module tb_reg_file_shadow;

  localparam int WIDTH = 8;
  localparam int DEPTH = 8;

  logic       CLK;
  logic       RESET;
  logic [7:0] in_d;
  logic [2:0] inaddr;
  logic [2:0] out1a;
  logic [2:0] out2a;
  logic       write;
  logic       save;
  logic       restore;

  int n_checks;
  int n_errors;

  reg_file_shadow_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_base ();
  reg_file_shadow_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_byp ();
  reg_file_shadow_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) if_zero ();

  assign if_base.IN = in_d;    assign if_byp.IN = in_d;    assign if_zero.IN = in_d;
  assign if_base.INADDRESS = inaddr;
  assign if_byp.INADDRESS  = inaddr;
  assign if_zero.INADDRESS = inaddr;
  assign if_base.WRITE = write; assign if_byp.WRITE = write; assign if_zero.WRITE = write;
  assign if_base.OUT1ADDRESS = out1a;
  assign if_byp.OUT1ADDRESS  = out1a;
  assign if_zero.OUT1ADDRESS = out1a;
  assign if_base.OUT2ADDRESS = out2a;
  assign if_byp.OUT2ADDRESS  = out2a;
  assign if_zero.OUT2ADDRESS = out2a;
  assign if_base.SAVE = save;   assign if_byp.SAVE = save;   assign if_zero.SAVE = save;
  assign if_base.RESTORE = restore;
  assign if_byp.RESTORE  = restore;
  assign if_zero.RESTORE = restore;

  reg_file_shadow #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1'b0), .ZERO_R0(1'b0))
    dut_base (.CLK(CLK), .RESET(RESET), .bus(if_base.slave));
  reg_file_shadow #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1'b1), .ZERO_R0(1'b0))
    dut_byp (.CLK(CLK), .RESET(RESET), .bus(if_byp.slave));
  reg_file_shadow #(.WIDTH(WIDTH), .DEPTH(DEPTH), .BYPASS(1'b0), .ZERO_R0(1'b1))
    dut_zero (.CLK(CLK), .RESET(RESET), .bus(if_zero.slave));

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    write  = 1'b1;
    inaddr = a;
    in_d   = d;
    tick();
    write  = 1'b0;
  endtask

  task automatic start(input logic s, input logic r);
    save    = s;
    restore = r;
    tick();
    save    = 1'b0;
    restore = 1'b0;
  endtask

  // Runs a fixed window after a copy start, counting base BUSY/DONE cycles.
  task automatic run_copy(output int busy_cnt, output int done_cnt);
    busy_cnt = 0;
    done_cnt = 0;
    for (int c = 0; c < 12; c++) begin
      #2;
      if (if_base.BUSY) busy_cnt++;
      if (if_base.DONE) done_cnt++;
      tick();
    end
  endtask

  int   busy_cnt;
  int   done_cnt;
  int   done_cyc;
  logic drop_seen [16];

  initial begin
    n_checks = 0;
    n_errors = 0;
    RESET = 1'b1;
    in_d = '0; inaddr = '0; out1a = '0; out2a = '0;
    write = 1'b0; save = 1'b0; restore = 1'b0;

    // Reset state
    tick();
    check("rst_busy",    if_base.BUSY,    1'b0);
    check("rst_done",    if_base.DONE,    1'b0);
    check("rst_wr_drop", if_base.WR_DROP, 1'b0);
    for (int a = 0; a < 8; a++) begin
      out1a = 3'(a);
      out2a = 3'(7 - a);
      #1;
      check($sformatf("rst_r%0d", a), if_base.OUT1, 8'h00);
    end
    tick();
    RESET = 1'b0;

    // Basic write / read
    wr(3'd3, 8'h5A);
    wr(3'd7, 8'hFF);
    out1a = 3'd3; out2a = 3'd7; #2;
    check("rd_base_o1", if_base.OUT1, 8'h5A);
    check("rd_base_o2", if_base.OUT2, 8'hFF);
    check("rd_byp_o1",  if_byp.OUT1,  8'h5A);
    check("rd_zero_o2", if_zero.OUT2, 8'hFF);
    tick();
    for (int a = 0; a < 7; a++) begin
      if (a != 3) begin
        out1a = 3'(a);
        #1;
        check($sformatf("rd_zero_fill_r%0d", a), if_base.OUT1, 8'h00);
      end
    end
    tick();

    // Bypass: same-cycle write visible only on the BYPASS instance
    wr(3'd2, 8'h11);
    write = 1'b1; inaddr = 3'd2; in_d = 8'h22; out1a = 3'd2; out2a = 3'd3; #2;
    check("byp_off_pre", if_base.OUT1, 8'h11);
    check("byp_on_pre",  if_byp.OUT1,  8'h22);
    check("byp_on_o2",   if_byp.OUT2,  8'h5A);
    tick();
    write = 1'b0; #2;
    check("byp_off_post", if_base.OUT1, 8'h22);
    check("byp_on_post",  if_byp.OUT1,  8'h22);
    tick();

    // Hardwired R0
    wr(3'd0, 8'h55);
    out1a = 3'd0; out2a = 3'd0; #2;
    check("r0_base",    if_base.OUT1, 8'h55);
    check("r0_zero_o1", if_zero.OUT1, 8'h00);
    check("r0_zero_o2", if_zero.OUT2, 8'h00);
    tick();

    // Save with a refused write in the middle
    for (int i = 0; i < 8; i++) wr(3'(i), 8'(8'h10 + i));
    start(1'b1, 1'b0);
    busy_cnt = 0; done_cnt = 0; done_cyc = -1;
    for (int c = 0; c < 16; c++) begin
      write = (c == 3); inaddr = 3'd4; in_d = 8'h99;
      #2;
      if (if_base.BUSY) busy_cnt++;
      if (if_base.DONE) begin done_cnt++; done_cyc = c; end
      drop_seen[c] = if_base.WR_DROP;
      tick();
    end
    write = 1'b0;
    check("save_busy_cycles", busy_cnt, 8);
    check("save_done_pulses", done_cnt, 1);
    check("save_done_cycle",  done_cyc, 7);
    check("wr_drop_before",   drop_seen[3], 1'b0);
    check("wr_drop_pulse",    drop_seen[4], 1'b1);
    check("wr_drop_after",    drop_seen[5], 1'b0);
    out1a = 3'd4; #2;
    check("r4_unchanged", if_base.OUT1, 8'h14);
    tick();

    // Overwrite then restore
    for (int i = 0; i < 8; i++) wr(3'(i), 8'hAA);
    out1a = 3'd5; #2;
    check("overwrite_r5", if_base.OUT1, 8'hAA);
    tick();
    start(1'b0, 1'b1);
    busy_cnt = 0; done_cnt = 0;
    for (int c = 0; c < 16; c++) begin
      out1a = 3'd0;
      #2;
      if (if_base.BUSY) busy_cnt++;
      if (if_base.DONE) done_cnt++;
      if (c == 4) begin
        check("restore_midread_base", if_base.OUT1, 8'h10);
        check("restore_midread_busy", if_base.BUSY, 1'b1);
        check("restore_midread_zero", if_zero.OUT1, 8'h00);
      end
      tick();
    end
    check("restore_busy_cycles", busy_cnt, 8);
    check("restore_done_pulses", done_cnt, 1);
    for (int i = 0; i < 8; i++) begin
      out1a = 3'(i); #2;
      check($sformatf("restored_base_r%0d", i), if_base.OUT1, 8'(8'h10 + i));
      check($sformatf("restored_zero_r%0d", i), if_zero.OUT1,
            (i == 0) ? 8'h00 : 8'(8'h10 + i));
      tick();
    end

    // Reset mid-restore
    start(1'b0, 1'b1);
    tick();
    tick();
    RESET = 1'b1; #1;
    check("midrst_busy",      if_base.BUSY, 1'b0);
    check("midrst_done",      if_base.DONE, 1'b0);
    check("midrst_zero_busy", if_zero.BUSY, 1'b0);
    tick();
    RESET = 1'b0;
    run_copy(busy_cnt, done_cnt);
    check("midrst_no_busy", busy_cnt, 0);
    check("midrst_no_done", done_cnt, 0);
    for (int i = 0; i < 8; i++) begin
      out1a = 3'(i); #2;
      check($sformatf("midrst_active_r%0d", i), if_base.OUT1, 8'h00);
      tick();
    end
    wr(3'd1, 8'h77);
    start(1'b0, 1'b1);
    run_copy(busy_cnt, done_cnt);
    out1a = 3'd1; #2;
    check("midrst_shadow_r1", if_base.OUT1, 8'h00);
    tick();

    // SAVE and RESTORE together: SAVE wins
    wr(3'd1, 8'h31);
    start(1'b1, 1'b1);
    run_copy(busy_cnt, done_cnt);
    check("both_done_pulses", done_cnt, 1);
    out1a = 3'd1; out2a = 3'd0; #2;
    check("both_active_base", if_base.OUT1, 8'h31);
    check("both_active_zero", if_zero.OUT1, 8'h31);
    check("both_zero_r0",     if_zero.OUT2, 8'h00);
    tick();
    wr(3'd1, 8'h00);
    start(1'b0, 1'b1);
    run_copy(busy_cnt, done_cnt);
    out1a = 3'd1; #2;
    check("both_shadow_base", if_base.OUT1, 8'h31);
    check("both_shadow_zero", if_zero.OUT1, 8'h31);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
